// File: rtl/dsp_mac_scheduler_if.sv
// Request, slice and response signals of dsp_mac_scheduler bundled as one port.
// The master side drives requests, the slice product and response backpressure.
interface dsp_mac_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      dsp_issue;
    logic [DATA_W-1:0]         dsp_a;
    logic [DATA_W-1:0]         dsp_b;
    logic [2*DATA_W-1:0]       dsp_p;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [2*DATA_W-1:0]       rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, dsp_p, rsp_ready,
        input  req_ready, dsp_issue, dsp_a, dsp_b, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, dsp_p, rsp_ready,
        output req_ready, dsp_issue, dsp_a, dsp_b, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/dsp_mac_scheduler.sv
// Round-robin sharing of one pipelined multiplier slice between NUM_REQ requesters,
// with an ID tag pipeline and a credit-protected in-order response FIFO.
module dsp_mac_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 18,
    parameter int unsigned PIPE_LAT   = 4,
    parameter int unsigned RESP_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    dsp_mac_scheduler_if.slave bus
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned P_W   = 2 * DATA_W;

    logic [ID_W-1:0]     rr_q, rr_d;
    logic [PIPE_LAT-1:0] tag_v_q;
    logic [ID_W-1:0]     tag_id_q [PIPE_LAT];
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_q, rd_q;
    logic [P_W-1:0]      mem_data_q [RESP_DEPTH];
    logic [ID_W-1:0]     mem_id_q [RESP_DEPTH];

    logic            found;
    logic [ID_W-1:0] gnt;
    logic [ID_W-1:0] idx;
    logic            not_empty;
    logic            credit_ok;
    logic            issue;
    logic            push;
    logic            pop;
    logic [CNT_W:0]  occ_after_pop;

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // A pop this cycle releases its slot immediately, so a full FIFO can still accept an issue.
    assign not_empty     = (count_q != '0);
    assign pop           = not_empty & bus.rsp_ready;
    assign push          = tag_v_q[PIPE_LAT-1];
    assign occ_after_pop = {1'b0, inflight_q} + {1'b0, count_q} - (CNT_W + 1)'(pop);
    assign credit_ok     = occ_after_pop < (CNT_W + 1)'(RESP_DEPTH);
    assign issue         = found & credit_ok & ~rst;

    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
    assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    assign rr_d       = issue ? ((gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1) : rr_q;

    assign bus.req_ready = issue ? (NUM_REQ'(1) << gnt) : '0;
    assign bus.dsp_issue = issue;
    assign bus.dsp_a     = issue ? bus.req_a[gnt*DATA_W +: DATA_W] : '0;
    assign bus.dsp_b     = issue ? bus.req_b[gnt*DATA_W +: DATA_W] : '0;
    assign bus.rsp_valid = not_empty;
    assign bus.rsp_data  = not_empty ? mem_data_q[rd_q] : '0;
    assign bus.rsp_id    = not_empty ? mem_id_q[rd_q] : '0;
    assign bus.busy      = (inflight_q != '0) | not_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= '0;
            tag_v_q    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            for (int unsigned k = 0; k < PIPE_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            tag_v_q[0]  <= issue;
            tag_id_q[0] <= gnt;
            for (int unsigned k = 1; k < PIPE_LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
            if (push) begin
                wr_q <= (wr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= (rd_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_q] <= bus.dsp_p;
            mem_id_q[wr_q]   <= tag_id_q[PIPE_LAT-1];
        end
    end
endmodule

// File: tb/tb_dsp_mac_scheduler.sv
// Bench for dsp_mac_scheduler: a PIPE_LAT-deep signed multiplier stands in for the slice,
// and an independent arbiter/credit model feeds a scoreboard of expected responses.
module tb_dsp_mac_scheduler;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_W     = 18;
    localparam int unsigned PIPE_LAT   = 4;
    localparam int unsigned RESP_DEPTH = 8;
    localparam int unsigned ID_W       = 2;
    localparam int unsigned P_W        = 2 * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_mac_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    dsp_mac_scheduler #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .PIPE_LAT(PIPE_LAT),
        .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [NUM_REQ-1:0][DATA_W-1:0] opa, opb;
    logic [NUM_REQ-1:0]             valid;
    logic                           rdy;

    assign bus.req_a     = opa;
    assign bus.req_b     = opb;
    assign bus.req_valid = valid;
    assign bus.rsp_ready = rdy;

    logic signed [P_W-1:0] slice_q [PIPE_LAT];
    always @(posedge clk) begin
        slice_q[0] <= $signed(bus.dsp_a) * $signed(bus.dsp_b);
        for (int k = 1; k < PIPE_LAT; k++) slice_q[k] <= slice_q[k-1];
    end
    assign bus.dsp_p = slice_q[PIPE_LAT-1];

    typedef struct {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  p;
        int unsigned     land;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;
    int unsigned tb_rr = 0;

    logic               e_issue, e_rv, e_pop, e_busy;
    logic [NUM_REQ-1:0] e_ready;
    logic [DATA_W-1:0]  e_a, e_b;
    logic [ID_W-1:0]    e_id;
    logic [P_W-1:0]     e_data;

    logic               o_issue, o_rv, o_pop, o_busy;
    logic [NUM_REQ-1:0] o_ready;
    logic [DATA_W-1:0]  o_a, o_b;
    logic [ID_W-1:0]    o_id;
    logic [P_W-1:0]     o_data;

    // One clock: predict from the model, sample #1 after the negedge, advance the model.
    task automatic step();
        int unsigned           g = 0;
        bit                    found = 1'b0;
        logic signed [P_W-1:0] pr;
        e_issue = 1'b0; e_ready = '0; e_a = '0; e_b = '0;
        e_rv = 1'b0; e_pop = 1'b0; e_id = '0; e_data = '0; e_busy = 1'b0;
        if (rst) begin
            sb.delete();
            tb_rr = 0;
        end else begin
            e_rv   = (sb.size() > 0) && (sb[0].land <= cyc);
            e_pop  = e_rv && rdy;
            e_busy = (sb.size() > 0);
            if (e_rv) begin
                e_id   = sb[0].id;
                e_data = sb[0].p;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && valid[(tb_rr + k) % NUM_REQ]) begin
                    found = 1'b1;
                    g     = (tb_rr + k) % NUM_REQ;
                end
            end
            if (found && (int'(sb.size()) - int'(e_pop)) < int'(RESP_DEPTH)) begin
                e_issue    = 1'b1;
                e_ready[g] = 1'b1;
                e_a        = opa[g];
                e_b        = opb[g];
            end
        end
        #1;
        o_issue = bus.dsp_issue; o_ready = bus.req_ready; o_a = bus.dsp_a; o_b = bus.dsp_b;
        o_rv = bus.rsp_valid; o_pop = bus.rsp_valid & rdy; o_id = bus.rsp_id;
        o_data = bus.rsp_data; o_busy = bus.busy;
        if (e_pop) void'(sb.pop_front());
        if (e_issue) begin
            pr = $signed(opa[g]) * $signed(opb[g]);
            sb.push_back('{id: ID_W'(g), p: pr, land: cyc + PIPE_LAT + 1});
            tb_rr = (g + 1) % NUM_REQ;
        end
        cyc++;
        @(negedge clk);
        if (e_issue) begin
            opa[g] = DATA_W'($urandom);
            opb[g] = DATA_W'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = '1; rdy = 1'b1;
        step();
        n_cmp++;
        if ({o_issue, o_ready, o_a, o_b, o_rv, o_busy, o_id, o_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got iss=%b rdy=%b a=%h b=%h rv=%b busy=%b id=%0d data=%h want all 0",
                     o_issue, o_ready, o_a, o_b, o_rv, o_busy, o_id, o_data);
        end
        rst = 1'b0; valid = '0;
        step();
        n_cmp++;
        if ({o_issue, o_ready, o_rv, o_busy} !== '0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got iss=%b rdy=%b rv=%b busy=%b want 0", o_issue, o_ready, o_rv, o_busy);
        end
    endtask

    task automatic test_drain();
        valid = '0; rdy = 1'b1;
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            step();
            n_cmp++;
            if ({o_issue, o_ready, o_a, o_b, o_rv, o_busy} !== {e_issue, e_ready, e_a, e_b, e_rv, e_busy}) begin
                n_bad++;
                $display("FAIL drain_ctrl cyc=%0d got iss=%b rdy=%b rv=%b busy=%b want iss=%b rdy=%b rv=%b busy=%b",
                         cyc, o_issue, o_ready, o_rv, o_busy, e_issue, e_ready, e_rv, e_busy);
            end
            if (e_pop) begin
                n_cmp++;
                if ({o_id, o_data} !== {e_id, e_data}) begin
                    n_bad++;
                    $display("FAIL drain_rsp cyc=%0d got id=%0d data=%h want id=%0d data=%h", cyc, o_id, o_data, e_id, e_data);
                end
            end
        end
        step();
        n_cmp++;
        if (o_busy !== 1'b0 || o_rv !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_idle: got busy=%b rv=%b want 0 0", o_busy, o_rv);
        end
    endtask

    task automatic test_single(input int unsigned req, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b, input logic [P_W-1:0] want);
        int unsigned     t_iss = 0;
        int unsigned     t_rsp = 0;
        bit              seen = 1'b0;
        logic            busy_after = 1'b1;
        logic [P_W-1:0]  got_d = '0;
        logic [ID_W-1:0] got_id = '0;
        rdy = 1'b1; valid = '0; valid[req] = 1'b1; opa[req] = a; opb[req] = b;
        step();
        t_iss = cyc - 1;
        n_cmp++;
        if ({o_issue, o_ready, o_a, o_b} !== {1'b1, NUM_REQ'(1) << req, a, b}) begin
            n_bad++;
            $display("FAIL single_issue req=%0d got iss=%b rdy=%b a=%h b=%h want iss=1 rdy=%b a=%h b=%h",
                     req, o_issue, o_ready, o_a, o_b, NUM_REQ'(1) << req, a, b);
        end
        valid = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!seen && o_rv) begin
                seen = 1'b1; t_rsp = cyc - 1; got_d = o_data; got_id = o_id;
            end
            if (cyc - 1 == t_iss + PIPE_LAT + 2) busy_after = o_busy;
            n_cmp++;
            if ({o_rv, o_busy} !== {e_rv, e_busy}) begin
                n_bad++;
                $display("FAIL single_flags cyc=%0d got rv=%b busy=%b want rv=%b busy=%b", cyc, o_rv, o_busy, e_rv, e_busy);
            end
        end
        n_cmp++;
        if (!seen || (t_rsp - t_iss) != PIPE_LAT + 1) begin
            n_bad++;
            $display("FAIL single_latency req=%0d got seen=%b latency=%0d want %0d", req, seen, t_rsp - t_iss, PIPE_LAT + 1);
        end
        n_cmp++;
        if ({got_id, got_d} !== {ID_W'(req), want}) begin
            n_bad++;
            $display("FAIL single_result got id=%0d data=%h want id=%0d data=%h", got_id, got_d, req, want);
        end
        n_cmp++;
        if (busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy_low got busy=%b want 0", busy_after);
        end
    endtask

    task automatic test_round_robin();
        int n_iss = 0;
        valid = '1; rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (o_issue) n_iss++;
            n_cmp++;
            if ({o_issue, o_ready, o_a, o_b, o_rv, o_busy} !== {e_issue, e_ready, e_a, e_b, e_rv, e_busy}) begin
                n_bad++;
                $display("FAIL rr_ctrl cyc=%0d got iss=%b rdy=%b a=%h b=%h rv=%b want iss=%b rdy=%b a=%h b=%h rv=%b",
                         cyc, o_issue, o_ready, o_a, o_b, o_rv, e_issue, e_ready, e_a, e_b, e_rv);
            end
            if (e_pop) begin
                n_cmp++;
                if ({o_id, o_data} !== {e_id, e_data}) begin
                    n_bad++;
                    $display("FAIL rr_rsp cyc=%0d got id=%0d data=%h want id=%0d data=%h", cyc, o_id, o_data, e_id, e_data);
                end
            end
        end
        n_cmp++;
        if (n_iss != 24) begin
            n_bad++;
            $display("FAIL rr_throughput got %0d issues want 24", n_iss);
        end
        test_drain();
    endtask

    task automatic test_backpressure();
        int n_iss = 0;
        valid = '1; rdy = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (o_issue) n_iss++;
            n_cmp++;
            if ({o_issue, o_ready, o_a, o_b, o_rv, o_busy} !== {e_issue, e_ready, e_a, e_b, e_rv, e_busy}) begin
                n_bad++;
                $display("FAIL bp_ctrl cyc=%0d got iss=%b rdy=%b rv=%b want iss=%b rdy=%b rv=%b",
                         cyc, o_issue, o_ready, o_rv, e_issue, e_ready, e_rv);
            end
        end
        n_cmp++;
        if (n_iss != int'(RESP_DEPTH) || o_ready !== '0) begin
            n_bad++;
            $display("FAIL bp_credit_stop got issues=%0d rdy=%b want issues=%0d rdy=0", n_iss, o_ready, RESP_DEPTH);
        end
        rdy = 1'b1;
        step();
        n_cmp++;
        if ({o_pop, o_issue} !== 2'b11) begin
            n_bad++;
            $display("FAIL bp_resume got pop=%b iss=%b want 1 1", o_pop, o_issue);
        end
        n_cmp++;
        if ({o_id, o_data} !== {e_id, e_data}) begin
            n_bad++;
            $display("FAIL bp_first_rsp got id=%0d data=%h want id=%0d data=%h", o_id, o_data, e_id, e_data);
        end
    endtask

    // Random backpressure with all requesters valid keeps the FIFO at its credit limit
    // while pushes and pops coincide.
    task automatic test_full_push_pop();
        int n_pop = 0;
        valid = '1;
        for (int i = 0; i < 80; i++) begin
            rdy = (i % 10 < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            step();
            if (o_pop) n_pop++;
            n_cmp++;
            if ({o_issue, o_ready, o_a, o_b, o_rv, o_busy} !== {e_issue, e_ready, e_a, e_b, e_rv, e_busy}) begin
                n_bad++;
                $display("FAIL full_ctrl cyc=%0d got iss=%b rdy=%b rv=%b busy=%b want iss=%b rdy=%b rv=%b busy=%b",
                         cyc, o_issue, o_ready, o_rv, o_busy, e_issue, e_ready, e_rv, e_busy);
            end
            if (e_pop) begin
                n_cmp++;
                if ({o_id, o_data} !== {e_id, e_data}) begin
                    n_bad++;
                    $display("FAIL full_rsp cyc=%0d got id=%0d data=%h want id=%0d data=%h", cyc, o_id, o_data, e_id, e_data);
                end
            end
        end
        n_cmp++;
        if (n_pop < 20) begin
            n_bad++;
            $display("FAIL full_progress got %0d pops want at least 20", n_pop);
        end
        test_drain();
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        valid = '1; rdy = 1'b0;
        for (int i = 0; i < 5; i++) step();
        valid = '0;
        step();
        n_cmp++;
        if ({o_rv, o_busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL rstmid_pre got rv=%b busy=%b want 1 1", o_rv, o_busy);
        end
        valid = '1; rdy = 1'b1; rst = 1'b1;
        step();
        n_cmp++;
        if ({o_issue, o_ready, o_a, o_b, o_rv, o_busy, o_id, o_data} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs got iss=%b rdy=%b rv=%b busy=%b id=%0d data=%h want all 0",
                     o_issue, o_ready, o_rv, o_busy, o_id, o_data);
        end
        step();
        valid = '0; rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_rv !== 1'b0 || o_busy !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_stale got a response or busy after reset want none");
        end
        valid = '1;
        step();
        n_cmp++;
        if ({o_issue, o_ready} !== {1'b1, 4'b0001}) begin
            n_bad++;
            $display("FAIL rstmid_first_grant got iss=%b rdy=%b want 1 0001", o_issue, o_ready);
        end
        test_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid = '0; rdy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = DATA_W'($urandom);
            opb[i] = DATA_W'($urandom);
        end
        @(negedge clk);
        test_reset();
        test_single(0, 18'd3, 18'd5, 36'd15);
        test_single(2, -18'sd2, 18'd7, 36'hF_FFFF_FFF2);
        test_round_robin();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
